// File: rtl/imem_program_loader.sv
// imem_program_loader
// Fills the 128x8 instruction memory from a framed byte stream
// (length, payload, checksum) and holds the core until a frame verifies.
// Byte k of the payload is written to IMEM address k.

module imem_program_loader #(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned BYTE_W = 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_n;
    logic [BYTE_W-1:0] len;
    logic [BYTE_W-1:0] len_n;
    logic [BYTE_W-1:0] cnt;
    logic [BYTE_W-1:0] cnt_n;
    logic [BYTE_W-1:0] sum;
    logic [BYTE_W-1:0] sum_n;
    logic              wr_en_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [BYTE_W-1:0] wr_data_n;
    logic              core_hold_n;
    logic              done_n;
    logic              err_n;
    logic              accept;
    logic              len_bad;
    logic              last_byte;

    // Loader takes bytes only while a frame is in progress.
    assign in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);

    assign accept = in_valid & in_ready;

    // Length must be non-zero, fit in IMEM and cover whole 32-bit instructions.
    assign len_bad = (in_byte == 8'd0)
                  || (32'(in_byte) > MEM_BYTES)
                  || (in_byte[1:0] != 2'b00);

    assign last_byte = (cnt == (len - 8'd1));

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_n   = state;
        len_n     = len;
        cnt_n     = cnt;
        sum_n     = sum;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LEN;
                    cnt_n   = '0;
                    sum_n   = '0;
                end
            end

            S_LEN: begin
                if (accept) begin
                    len_n   = in_byte;
                    state_n = len_bad ? S_ERR : S_DATA;
                end
            end

            S_DATA: begin
                if (accept) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = ADDR_W'(cnt);
                    wr_data_n = in_byte;
                    sum_n     = sum + in_byte;
                    cnt_n     = cnt + 8'd1;
                    if (last_byte) begin
                        state_n = S_CSUM;
                    end
                end
            end

            S_CSUM: begin
                if (accept) begin
                    state_n = (in_byte == sum) ? S_DONE : S_ERR;
                end
            end

            // Reload or retry; in_ready is low here so a coincident byte is dropped.
            S_DONE, S_ERR: begin
                if (start) begin
                    state_n = S_LEN;
                    cnt_n   = '0;
                    sum_n   = '0;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        done_n      = (state_n == S_DONE);
        err_n       = (state_n == S_ERR);
        core_hold_n = (state_n != S_DONE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            len       <= '0;
            cnt       <= '0;
            sum       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            cnt       <= cnt_n;
            sum       <= sum_n;
            wr_en     <= wr_en_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            core_hold <= core_hold_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader.

module tb_imem_program_loader;

    localparam int unsigned MEM_BYTES = 128;
    localparam int unsigned ADDR_W    = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              core_hold;
    logic              done;
    logic              err;

    int checks;
    int failures;

    logic [ADDR_W-1:0] log_addr [$];
    logic [7:0]        log_data [$];
    logic [7:0]        mem [MEM_BYTES];

    imem_program_loader #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .core_hold (core_hold),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture IMEM writes mid-cycle into a log and a shadow memory.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            mem[wr_addr[6:0]] = wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, core_hold, done, err} !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b exp 0 0 00 00 1 0 0",
                     in_ready, wr_en, wr_addr, wr_data, core_hold, done, err);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0 || core_hold !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_reset got rdy=%b hold=%b exp rdy=0 hold=1", in_ready, core_hold);
        end
    endtask

    // T1: basic 8-byte frame, one-cycle write latency.
    task automatic test_basic_frame();
        logic [7:0] d [8];
        d = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_log();
        pulse_start();
        checks++;
        if (in_ready !== 1'b1 || core_hold !== 1'b1) begin
            failures++;
            $display("FAIL t1_len_state got rdy=%b hold=%b exp rdy=1 hold=1", in_ready, core_hold);
        end
        send_byte(8'h08);
        checks++;
        if (wr_en !== 1'b0) begin
            failures++;
            $display("FAIL t1_no_write_on_len got wr_en=%b exp 0", wr_en);
        end
        for (int i = 0; i < 8; i++) begin
            send_byte(d[i]);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 8'(i) || wr_data !== d[i]) begin
                failures++;
                $display("FAIL t1_write%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h",
                         i, wr_en, wr_addr, wr_data, 8'(i), d[i]);
            end
        end
        send_byte(8'h2D);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || core_hold !== 1'b0 || in_ready !== 1'b0 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL t1_done got done=%b err=%b hold=%b rdy=%b we=%b exp 1 0 0 0 0",
                     done, err, core_hold, in_ready, wr_en);
        end
        checks++;
        if (log_addr.size() !== 8) begin
            failures++;
            $display("FAIL t1_write_count got %0d exp 8", log_addr.size());
        end
        // Bytes presented while idle in DONE are ignored.
        in_valid = 1'b1;
        in_byte  = 8'h55;
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || log_addr.size() !== 8) begin
            failures++;
            $display("FAIL t1_done_ignores_bytes got done=%b writes=%0d exp done=1 writes=8",
                     done, log_addr.size());
        end
    endtask

    // T2: length not a multiple of 4, plus zero and over-capacity lengths.
    task automatic test_bad_length();
        logic [7:0] lens [3];
        lens = '{8'h06, 8'h00, 8'h84};
        for (int i = 0; i < 3; i++) begin
            clear_log();
            pulse_start();
            checks++;
            if (core_hold !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL t2_restart%0d got hold=%b done=%b exp hold=1 done=0", i, core_hold, done);
            end
            send_byte(lens[i]);
            tick();
            checks++;
            if (err !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1 || in_ready !== 1'b0 || log_addr.size() !== 0) begin
                failures++;
                $display("FAIL t2_len%h got err=%b done=%b hold=%b rdy=%b writes=%0d exp 1 0 1 0 0",
                         lens[i], err, done, core_hold, in_ready, log_addr.size());
            end
        end
    endtask

    // T3: wrong checksum after 4 written bytes.
    task automatic test_bad_checksum();
        clear_log();
        pulse_start();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL t3_err_cleared got err=%b exp 0", err);
        end
        send_byte(8'h04);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        send_byte(8'h0B);
        tick();
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1) begin
            failures++;
            $display("FAIL t3_err got err=%b done=%b hold=%b exp 1 0 1", err, done, core_hold);
        end
        checks++;
        if (log_addr.size() !== 4 || log_addr[3] !== 8'h03 || log_data[3] !== 8'h04) begin
            failures++;
            $display("FAIL t3_writes got n=%0d exp n=4 last a=03 d=04", log_addr.size());
        end
    endtask

    // T4: in_valid toggling during DATA gives gapless addresses.
    task automatic test_valid_toggle();
        clear_log();
        pulse_start();
        send_byte(8'h08);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'h11 * (i + 1)));
            in_byte = 8'hFF;
            tick();
        end
        send_byte(8'h64);
        tick();
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL t4_done got done=%b err=%b exp 1 0", done, err);
        end
        checks++;
        if (log_addr.size() !== 8) begin
            failures++;
            $display("FAIL t4_write_count got %0d exp 8", log_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_addr[i] !== 8'(i) || log_data[i] !== 8'(8'h11 * (i + 1))) begin
                    failures++;
                    $display("FAIL t4_write%0d got a=%h d=%h exp a=%h d=%h",
                             i, log_addr[i], log_data[i], 8'(i), 8'(8'h11 * (i + 1)));
                end
            end
        end
    endtask

    // Start with a coincident byte in DONE: start wins, byte dropped.
    task automatic test_start_priority();
        clear_log();
        start    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h06;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || err !== 1'b0 || core_hold !== 1'b1) begin
            failures++;
            $display("FAIL start_prio_len got rdy=%b err=%b hold=%b exp 1 0 1", in_ready, err, core_hold);
        end
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h04);
        tick();
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || log_addr.size() !== 4) begin
            failures++;
            $display("FAIL start_prio_frame got done=%b err=%b writes=%0d exp 1 0 4",
                     done, err, log_addr.size());
        end
    endtask

    // T5: full 128-byte image, then reload 4 bytes with a stray start mid-frame.
    task automatic test_full_and_reload();
        logic [7:0] s;
        logic [7:0] nd [4];
        int         bad;
        nd = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clear_log();
        s = 8'h00;
        pulse_start();
        in_valid = 1'b1;
        in_byte  = 8'h80;
        tick();
        for (int k = 0; k < 128; k++) begin
            in_byte = 8'(k * 3 + 1);
            s       = s + 8'(k * 3 + 1);
            tick();
        end
        in_byte = s;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || log_addr.size() !== 128) begin
            failures++;
            $display("FAIL t5_full got done=%b err=%b writes=%0d exp 1 0 128", done, err, log_addr.size());
        end
        bad = 0;
        for (int k = 0; k < log_addr.size(); k++) begin
            if (log_addr[k] !== 8'(k) || log_data[k] !== 8'(k * 3 + 1)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL t5_full_contents got %0d bad writes exp 0", bad);
        end

        clear_log();
        pulse_start();
        checks++;
        if (core_hold !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL t5_reload_hold got hold=%b done=%b exp 1 0", core_hold, done);
        end
        send_byte(8'h04);
        send_byte(nd[0]);
        send_byte(nd[1]);
        start = 1'b1;
        send_byte(nd[2]);
        start = 1'b0;
        send_byte(nd[3]);
        send_byte(8'h0E);
        tick();
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || log_addr.size() !== 4) begin
            failures++;
            $display("FAIL t5_reload got done=%b err=%b writes=%0d exp 1 0 4", done, err, log_addr.size());
        end
        bad = 0;
        for (int k = 0; k < 128; k++) begin
            if (k < 4) begin
                if (mem[k] !== nd[k]) bad++;
            end else if (mem[k] !== 8'(k * 3 + 1)) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL t5_image_after_reload got %0d bad bytes exp 0", bad);
        end
    endtask

    // T6: reset during DATA at cnt=3, then a clean reload.
    task automatic test_reset_mid_frame();
        clear_log();
        pulse_start();
        send_byte(8'h08);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        #5;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, core_hold, done, err} !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL t6_async_reset got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b exp 0 0 00 00 1 0 0",
                     in_ready, wr_en, wr_addr, wr_data, core_hold, done, err);
        end
        in_valid = 1'b1;
        in_byte  = 8'h77;
        tick();
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        checks++;
        if (log_addr.size() !== 3 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL t6_no_write_in_reset got writes=%0d rdy=%b exp 3 0", log_addr.size(), in_ready);
        end
        clear_log();
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h0A);
        tick();
        checks++;
        if (done !== 1'b1 || core_hold !== 1'b0 || log_addr.size() !== 4 || log_addr[0] !== 8'h00) begin
            failures++;
            $display("FAIL t6_reload got done=%b hold=%b writes=%0d exp 1 0 4", done, core_hold, log_addr.size());
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        for (int k = 0; k < 128; k++) mem[k] = 8'h00;
        test_reset();
        test_basic_frame();
        test_bad_length();
        test_bad_checksum();
        test_valid_toggle();
        test_start_priority();
        test_full_and_reload();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
